fc_act_loader: RTL and testbench

- Streaming front end for the fully-parallel FC neuron layer.
- Accepts activations one per beat on a valid/ready stream and packs them into an IN-entry vector, WIDTH bits per entry, that drives the layer's x[0:IN-1] input.
- Ping-pong double buffered: one bank fills while the other is held stable for the combinational multiply/adder-tree/ReLU path and its downstream capture register.

---
 rtl/fc_pkg.sv | 14 +
 rtl/fc_act_loader_if.sv | 40 ++++
 rtl/fc_act_bank.sv | 29 ++
 rtl/fc_act_loader.sv | 106 ++++++++++
 tb/tb_fc_act_loader.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/fc_pkg.sv
// Shared sizing and types for the FC layer front end.
package fc_pkg;

   localparam int FC_IN    = 128;
   localparam int FC_WIDTH = 8;

   typedef logic [FC_WIDTH-1:0] act_t;

   // Index width for an n-entry vector; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fc_act_loader_if.sv
// Activation stream in, packed activation vector out, for the FC layer loader.
interface fc_act_loader_if
   import fc_pkg::*;
#(
   parameter int WIDTH = $bits(act_t),
   parameter int IN    = FC_IN
);

   logic             s_valid;
   logic             s_ready;
   logic [WIDTH-1:0] s_data;
   logic             s_last;
   logic [WIDTH-1:0] x [0:IN-1];
   logic             x_valid;
   logic             x_ready;
   logic             err_len;

   modport slave (
      input  s_valid,
      input  s_data,
      input  s_last,
      input  x_ready,
      output s_ready,
      output x,
      output x_valid,
      output err_len
   );

   modport master (
      output s_valid,
      output s_data,
      output s_last,
      output x_ready,
      input  s_ready,
      input  x,
      input  x_valid,
      input  err_len
   );

endinterface

// File: rtl/fc_act_bank.sv
// One IN x WIDTH activation register bank with single-entry write and whole-bank clear.
module fc_act_bank
   import fc_pkg::*;
#(
   parameter  int WIDTH = $bits(act_t),
   parameter  int IN    = FC_IN,
   localparam int CW    = cnt_width(IN)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [CW-1:0]    wr_idx,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             clr,
   output logic [WIDTH-1:0] q [0:IN-1]
);

   // Clear is a parallel zeroing of the whole bank so short frames leave zeros behind.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         for (int i = 0; i < IN; i++) begin
            q[i] <= '0;
         end
      end else if (wr_en) begin
         q[wr_idx] <= wr_data;
      end
   end

endmodule

// File: rtl/fc_act_loader.sv
// Ping-pong loader: packs streamed activations into a vector held stable for the FC layer.
module fc_act_loader
   import fc_pkg::*;
#(
   parameter int WIDTH = $bits(act_t),
   parameter int IN    = FC_IN
) (
   input  logic             clk,
   input  logic             rst,
   fc_act_loader_if.slave   bus
);

   localparam int            CW       = cnt_width(IN);
   localparam logic [CW-1:0] LAST_IDX = CW'(IN - 1);

   logic [CW-1:0]    cnt;
   logic             wr_bank;
   logic             rd_bank;
   logic [1:0]       full;
   logic [1:0]       full_next;
   logic             err_q;

   logic             accept;
   logic             at_end;
   logic             close;
   logic             rel;

   logic [WIDTH-1:0] q0 [0:IN-1];
   logic [WIDTH-1:0] q1 [0:IN-1];

   assign bus.s_ready = !full[wr_bank];
   assign bus.x_valid = full[rd_bank];
   assign bus.err_len = err_q;

   assign accept = bus.s_valid && bus.s_ready;
   assign at_end = (cnt == LAST_IDX);
   assign close  = accept && (bus.s_last || at_end);
   assign rel    = full[rd_bank] && bus.x_ready;

   // Close and release always target different banks, since a full bank refuses writes.
   always_comb begin
      full_next = full;
      if (close) begin
         full_next[wr_bank] = 1'b1;
      end
      if (rel) begin
         full_next[rd_bank] = 1'b0;
      end
   end

   // A length error is a close where s_last and the end-of-vector index disagree.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         full    <= 2'b00;
         err_q   <= 1'b0;
      end else begin
         full  <= full_next;
         err_q <= accept && (bus.s_last != at_end);
         if (accept) begin
            cnt <= close ? '0 : cnt + 1'b1;
         end
         if (close) begin
            wr_bank <= !wr_bank;
         end
         if (rel) begin
            rd_bank <= !rd_bank;
         end
      end
   end

   fc_act_bank #(
      .WIDTH (WIDTH),
      .IN    (IN)
   ) u_bank0 (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (accept && !wr_bank),
      .wr_idx  (cnt),
      .wr_data (bus.s_data),
      .clr     (rel && !rd_bank),
      .q       (q0)
   );

   fc_act_bank #(
      .WIDTH (WIDTH),
      .IN    (IN)
   ) u_bank1 (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (accept && wr_bank),
      .wr_idx  (cnt),
      .wr_data (bus.s_data),
      .clr     (rel && rd_bank),
      .q       (q1)
   );

   always_comb begin
      for (int i = 0; i < IN; i++) begin
         bus.x[i] = rd_bank ? q1[i] : q0[i];
      end
   end

endmodule

// File: tb/tb_fc_act_loader.sv
// Directed bench for fc_act_loader: framing, ping-pong hand-off, length errors and reset.
module tb_fc_act_loader;

   localparam int WIDTH = 8;
   localparam int IN    = fc_pkg::FC_IN;

   logic clk = 1'b0;
   logic rst;

   int checks      = 0;
   int errors      = 0;
   int acceptCount = 0;
   int errPulses   = 0;
   int cycle       = 0;

   fc_act_loader_if #(.WIDTH(WIDTH), .IN(IN)) bus ();

   fc_act_loader #(
      .WIDTH (WIDTH),
      .IN    (IN)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cycle++;
      if (!rst && bus.s_valid && bus.s_ready) begin
         acceptCount++;
      end
   end

   always @(negedge clk) begin
      if (bus.err_len) begin
         errPulses++;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Presents one beat from a negedge and returns on the negedge after it is accepted.
   task automatic applyStimulus(input logic [WIDTH-1:0] d, input logic last);
      int waited = 0;
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      bus.s_last  = last;
      while (!bus.s_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.s_ready) begin
         checkOutput("beatTimeout", 32'd0, 32'd1);
      end else begin
         @(negedge clk);
      end
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
   endtask

   task automatic pulseRelease();
      bus.x_ready = 1'b1;
      @(negedge clk);
      bus.x_ready = 1'b0;
   endtask

   function automatic int nonZeroEntries();
      int n = 0;
      for (int i = 0; i < IN; i++) begin
         if (bus.x[i] != '0) n++;
      end
      return n;
   endfunction

   initial begin
      int readyDrops;
      int c0;
      int a0;
      int e0;

      rst         = 1'b1;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.s_last  = 1'b0;
      bus.x_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rstReady", bus.s_ready, 1);
      checkOutput("rstValid", bus.x_valid, 0);
      checkOutput("rstErr", bus.err_len, 0);
      checkOutput("rstXZero", nonZeroEntries(), 0);

      // Frame 1 into bank 0, nothing released.
      for (int i = 0; i < IN; i++) begin
         if (i == IN - 1) checkOutput("f1ValidEarly", bus.x_valid, 0);
         applyStimulus(8'(i), i == IN - 1);
      end
      checkOutput("f1Valid", bus.x_valid, 1);
      checkOutput("f1X5", bus.x[5], 8'd5);
      checkOutput("f1X127", bus.x[127], 8'd127);

      // Frame 2 into bank 1 with no bubble; frame 1 must stay on x.
      readyDrops = 0;
      c0 = cycle;
      for (int i = 0; i < IN; i++) begin
         if (!bus.s_ready) readyDrops++;
         applyStimulus(8'hA0 + 8'(i % 16), i == IN - 1);
      end
      checkOutput("f2ReadyDrops", readyDrops, 0);
      checkOutput("f2Cycles", cycle - c0, 128);
      checkOutput("f2ReadyLow", bus.s_ready, 0);
      checkOutput("f2ValidHeld", bus.x_valid, 1);
      checkOutput("f2X0Held", bus.x[0], 8'd0);
      checkOutput("f2X5Held", bus.x[5], 8'd5);
      checkOutput("f2X127Held", bus.x[127], 8'd127);
      checkOutput("f2ErrNone", errPulses, 0);

      // Both banks full: an offered beat must not be taken.
      a0 = acceptCount;
      bus.s_valid = 1'b1;
      bus.s_data  = 8'hFF;
      repeat (5) @(negedge clk);
      checkOutput("stallNoAccept", acceptCount - a0, 0);
      checkOutput("stallX5", bus.x[5], 8'd5);
      bus.s_valid = 1'b0;

      pulseRelease();
      checkOutput("relX0", bus.x[0], 8'hA0);
      checkOutput("relX15", bus.x[15], 8'hAF);
      checkOutput("relX16", bus.x[16], 8'hA0);
      checkOutput("relValid", bus.x_valid, 1);
      checkOutput("relReady", bus.s_ready, 1);

      // Frame 3 re-uses bank 0; release bank 1 part way to look at it.
      for (int i = 0; i < 50; i++) begin
         applyStimulus(8'(i) ^ 8'h5A, 1'b0);
      end
      pulseRelease();
      checkOutput("f3PartValid", bus.x_valid, 0);
      checkOutput("f3X49", bus.x[49], 8'h6B);
      checkOutput("f3X100Empty", bus.x[100], 8'h00);
      for (int i = 50; i < IN; i++) begin
         applyStimulus(8'(i) ^ 8'h5A, i == IN - 1);
      end
      checkOutput("f3Valid", bus.x_valid, 1);
      checkOutput("f3X100", bus.x[100], 8'h3E);
      pulseRelease();
      checkOutput("f3RelValid", bus.x_valid, 0);

      // Short frame: s_last on beat 10.
      e0 = errPulses;
      for (int i = 0; i <= 10; i++) begin
         applyStimulus(8'h11, i == 10);
      end
      checkOutput("shortErrPulse", bus.err_len, 1);
      checkOutput("shortValid", bus.x_valid, 1);
      @(negedge clk);
      checkOutput("shortErrOnce", bus.err_len, 0);
      repeat (2) @(negedge clk);
      checkOutput("shortErrCount", errPulses - e0, 1);
      checkOutput("shortX0", bus.x[0], 8'h11);
      checkOutput("shortX10", bus.x[10], 8'h11);
      checkOutput("shortX11", bus.x[11], 8'h00);
      checkOutput("shortX127", bus.x[127], 8'h00);
      pulseRelease();

      // Missing s_last: 130 beats, closes at 128 and spills two beats.
      e0 = errPulses;
      for (int i = 0; i < 130; i++) begin
         applyStimulus(8'(i + 3), 1'b0);
         if (i == IN - 1) checkOutput("longErrPulse", bus.err_len, 1);
      end
      repeat (2) @(negedge clk);
      checkOutput("longErrCount", errPulses - e0, 1);
      checkOutput("longValid", bus.x_valid, 1);
      checkOutput("longX0", bus.x[0], 8'h03);
      checkOutput("longX127", bus.x[127], 8'h82);
      pulseRelease();
      checkOutput("spillValid", bus.x_valid, 0);
      checkOutput("spillX0", bus.x[0], 8'h83);
      checkOutput("spillX1", bus.x[1], 8'h84);
      checkOutput("spillX2", bus.x[2], 8'h00);

      // Extend the spilled frame to 60 beats, then reset mid-frame.
      for (int i = 2; i < 60; i++) begin
         applyStimulus(8'h77, 1'b0);
      end
      checkOutput("midX59", bus.x[59], 8'h77);
      e0 = errPulses;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("midRstReady", bus.s_ready, 1);
      checkOutput("midRstValid", bus.x_valid, 0);
      checkOutput("midRstXZero", nonZeroEntries(), 0);
      checkOutput("midRstErr", bus.err_len, 0);

      // x_ready with nothing presented must not advance the read bank.
      pulseRelease();
      for (int i = 0; i < IN; i++) begin
         applyStimulus(~8'(i), i == IN - 1);
      end
      checkOutput("freshValid", bus.x_valid, 1);
      checkOutput("freshX0", bus.x[0], 8'hFF);
      checkOutput("freshX127", bus.x[127], 8'h80);
      repeat (2) @(negedge clk);
      checkOutput("freshErrNone", errPulses - e0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
